// File: rtl/ebr_fifo_pkg.sv
// rtl/ebr_fifo_pkg.sv - shared constants and sizing helper for the EBR-backed stream FIFO
package ebr_fifo_pkg;

  localparam int EBR_DATA_W = 16;
  localparam logic [EBR_DATA_W-1:0] EBR_MASK_ALL_WRITE = 16'h0000;

  // Words held in the EBR plus the two-entry output buffer.
  function automatic int fifo_capacity(input int addr_w);
    return (1 << addr_w) + 2;
  endfunction

endpackage

// File: rtl/ebr_fifo_obuf.sv
// rtl/ebr_fifo_obuf.sv - two-entry first-word-fall-through output buffer
module ebr_fifo_obuf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [1:0]        cnt_o
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop_ok;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    pop_ok = pop_i && (cnt_q != 2'd0);
    case (cnt_q)
      2'd0: begin
        if (load_i) begin
          head_d = load_data_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (load_i && pop_ok) begin
          head_d = load_data_i;
        end else if (load_i) begin
          tail_d = load_data_i;
          cnt_d  = 2'd2;
        end else if (pop_ok) begin
          cnt_d  = 2'd0;
        end
      end
      default: begin
        // The controller never loads a full buffer unless it is also popping.
        if (pop_ok) begin
          head_d = tail_q;
          if (load_i) begin
            tail_d = load_data_i;
          end else begin
            cnt_d  = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = (cnt_q != 2'd0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/ebr_stream_fifo_ctrl.sv
// rtl/ebr_stream_fifo_ctrl.sv - valid/ready FIFO controller driving one 16-bit iCE40UP EBR
module ebr_stream_fifo_ctrl
  import ebr_fifo_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int AFULL_LVL = (1 << ADDR_W) - 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  s_afull,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_W+1:0]     level,
  output logic [ADDR_W-1:0]     ram_waddr,
  output logic [EBR_DATA_W-1:0] ram_wdata,
  output logic                  ram_we,
  output logic [EBR_DATA_W-1:0] ram_mask,
  output logic [ADDR_W-1:0]     ram_raddr,
  output logic                  ram_re,
  input  logic [EBR_DATA_W-1:0] ram_rdata
);

  localparam int LW = ADDR_W + 2;
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] RAM_DEPTH = CW'(1 << ADDR_W);
  localparam logic [LW-1:0] AFULL_V   = LW'(AFULL_LVL);
  localparam logic [LW-1:0] CAP_V     = LW'(fifo_capacity(ADDR_W));

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CW-1:0]     ram_cnt_q, ram_cnt_d;
  logic              inflight_q, inflight_d;
  logic [LW-1:0]     level_q, level_d;
  logic              s_ready_q, s_ready_d;
  logic              s_afull_q, s_afull_d;
  logic [1:0]        obuf_cnt;
  logic [2:0]        buf_after;
  logic              push, pop, rd;

  assign push = s_valid && s_ready_q && !flush && !reset;
  assign pop  = m_valid && m_ready;

  // Prefetch only while the buffer plus the word already in flight leaves a free slot.
  assign buf_after = {1'b0, obuf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd = (ram_cnt_q != '0) && (buf_after < 3'd2) && !flush && !reset;

  always_comb begin
    wptr_d     = wptr_q + ADDR_W'(push);
    rptr_d     = rptr_q + ADDR_W'(rd);
    ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(rd);
    inflight_d = rd;
    level_d    = level_q + LW'(push) - LW'(pop);
    s_ready_d  = (ram_cnt_d < RAM_DEPTH);
    s_afull_d  = (level_d >= AFULL_V);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      level_q    <= '0;
      s_ready_q  <= 1'b1;
      s_afull_q  <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
      s_ready_q  <= s_ready_d;
      s_afull_q  <= s_afull_d;
    end
  end

  // Clearing the buffer on flush also drops the EBR word returning that edge.
  ebr_fifo_obuf #(
    .DATA_W (DATA_W)
  ) u_obuf (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (flush),
    .load_i      (inflight_q),
    .load_data_i (ram_rdata[DATA_W-1:0]),
    .pop_i       (pop),
    .data_o      (m_data),
    .valid_o     (m_valid),
    .cnt_o       (obuf_cnt)
  );

  assign s_ready   = s_ready_q;
  assign s_afull   = s_afull_q;
  assign level     = level_q;
  assign ram_we    = push;
  assign ram_waddr = wptr_q;
  assign ram_wdata = EBR_DATA_W'(s_data);
  assign ram_mask  = EBR_MASK_ALL_WRITE;
  assign ram_raddr = rptr_q;
  assign ram_re    = rd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!ram_we || s_ready_q);
      assert (level_q <= CAP_V);
      assert (!ram_re || (ram_cnt_q != '0));
    end
  end

endmodule

// File: tb/tb_ebr_stream_fifo_ctrl.sv
// tb/tb_ebr_stream_fifo_ctrl.sv - randomized scoreboard bench for ebr_stream_fifo_ctrl
module tb_ebr_stream_fifo_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;
  localparam int CAP    = 258;
  localparam int AFULL  = 252;

  logic              clk = 1'b0;
  logic              reset, flush, s_valid, s_ready, s_afull, m_valid, m_ready;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] s_data, m_data;
  logic [15:0]       ram_wdata, ram_mask, ram_rdata;
  logic [ADDR_W+1:0] level;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [15:0]       mem [DEPTH];

  always #5 clk = ~clk;

  ebr_stream_fifo_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .AFULL_LVL (AFULL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_afull   (s_afull),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .level     (level),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_mask  (ram_mask),
    .ram_raddr (ram_raddr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  logic [15:0] q[$];
  int checks = 0;
  int errors = 0;
  int wcount = 0;
  int npush  = 0;
  int wraps  = 0;
  logic last_pop, prev_re;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic push, pop;
    @(negedge clk);
    push = s_valid && s_ready && !flush && !reset;
    pop  = m_valid && m_ready;
    if (!reset) begin
      check_eq("level", level, q.size());
      check_eq("s_afull", s_afull, q.size() >= AFULL);
      check_eq("ram_we", ram_we, push);
      check_eq("ram_mask", ram_mask, 32'h0);
      if (q.size() < DEPTH) check_eq("s_ready_room", s_ready, 1);
      if (q.size() == CAP) check_eq("s_ready_full", s_ready, 0);
      if (q.size() == 0) check_eq("m_valid_empty", m_valid, 0);
      if (m_valid && q.size() > 0) check_eq("m_data", m_data, q[0]);
      if (push) check_eq("ram_waddr", ram_waddr, wcount % DEPTH);
    end
    last_pop = pop;
    prev_re  = ram_re;
    if (push && ram_waddr == 0) wraps++;
    @(posedge clk);
    if (reset || flush) begin
      q.delete();
      wcount = 0;
    end else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (push) begin
        q.push_back(s_data);
        wcount++;
        npush++;
      end
    end
    #1;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (q.size() > 0 && cyc < 2000) begin
      cycle();
      cyc++;
    end
    check_eq("drain_done", level, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, gaps, maxlvl;
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) cycle();
    reset = 1'b0;
    check_eq("rst_s_ready", s_ready, 1);
    check_eq("rst_s_afull", s_afull, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_ram_we", ram_we, 0);
    check_eq("rst_ram_re", ram_re, 0);

    // single word latency
    s_valid = 1'b1; s_data = 16'hA5A5;
    cycle();
    s_valid = 1'b0;
    check_eq("lat_k", m_valid, 0);
    cycle();
    check_eq("lat_k1", m_valid, 0);
    cycle();
    check_eq("lat_k2", m_valid, 1);
    check_eq("lat_data", m_data, 16'hA5A5);
    check_eq("lat_level", level, 1);
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    check_eq("pop_level", level, 0);
    check_eq("pop_m_valid", m_valid, 0);

    // fill to capacity with the consumer stalled
    s_valid = 1'b1; cyc = 0;
    while (q.size() < CAP && cyc < 1000) begin
      s_data = 16'(q.size());
      cycle();
      cyc++;
      if (q.size() == AFULL - 1) check_eq("afull_251", s_afull, 0);
      if (q.size() == AFULL) check_eq("afull_252", s_afull, 1);
    end
    check_eq("fill_in_time", cyc < 1000, 1);
    check_eq("full_level", level, CAP);
    check_eq("full_s_ready", s_ready, 0);
    s_data = 16'hDEAD;
    repeat (3) cycle();
    check_eq("full_hold", level, CAP);

    // pop while full: no push that cycle, push accepted on the next
    m_ready = 1'b1; s_data = 16'(CAP);
    cycle();
    check_eq("full_pop", level, CAP - 1);
    m_ready = 1'b0;
    check_eq("ready_after_pop", s_ready, 1);
    cycle();
    check_eq("full_repush", level, CAP);
    drain();

    // streaming at one word per cycle
    s_valid = 1'b1; m_ready = 1'b1; gaps = 0; maxlvl = 0;
    for (int i = 0; i < 1000; i++) begin
      s_data = 16'(i + 16'h1000);
      cycle();
      if (i >= 3 && !last_pop) gaps++;
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    check_eq("stream_gaps", gaps, 0);
    check_eq("stream_maxlvl", maxlvl <= 3, 1);
    drain();

    // random traffic with both sides throttled
    npush = 0; wraps = 0; cyc = 0;
    while (npush < 5000 && cyc < 40000) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      cycle();
      cyc++;
    end
    check_eq("rand_in_time", npush >= 5000, 1);
    check_eq("rand_wraps", wraps > 10, 1);
    drain();

    // flush with a read in flight
    m_ready = 1'b0; s_valid = 1'b1; cyc = 0;
    while (q.size() < 101 && cyc < 500) begin
      s_data = 16'($urandom);
      cycle();
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    cycle();
    check_eq("pre_flush_read", prev_re, 1);
    check_eq("pre_flush_level", level, 100);
    m_ready = 1'b0; flush = 1'b1; s_valid = 1'b1; s_data = 16'hBEEF;
    cycle();
    flush = 1'b0; s_valid = 1'b0;
    check_eq("flush_m_valid", m_valid, 0);
    check_eq("flush_level", level, 0);
    check_eq("flush_s_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 16'h1234;
    cycle();
    s_valid = 1'b0; m_ready = 1'b1; cyc = 0;
    while (!m_valid && cyc < 5) begin
      cycle();
      cyc++;
    end
    check_eq("flush_first_valid", m_valid, 1);
    check_eq("flush_first_data", m_data, 16'h1234);
    drain();
    check_eq("end_m_valid", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
